// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU run/debug sequencer.
//   - state_t : sequencer state encodings as seen on the 'state' output
//   - cmd_t   : command codes accepted on the command interface
//   - DEF_PC_W / DEF_CNT_W : default widths for the PC and the counters
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEF_PC_W  = 8;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [2:0] {
        S_PAUSED = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_BREAK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_RUN     = 3'd1,
        CMD_PAUSE   = 3'd2,
        CMD_STEP    = 3'd3,
        CMD_SET_BP  = 3'd4,
        CMD_CLR_BP  = 3'd5,
        CMD_CLR_CNT = 3'd6,
        CMD_RSVD    = 3'd7
    } cmd_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl_if
// Bundles the command channel, the CPU status inputs and the sequencer
// outputs of cpu_run_ctrl.
//   master : the side issuing commands and reporting CPU status (bench/host)
//   slave  : the sequencer itself
// Signals:
//   cmd_valid/cmd/cmd_addr/cmd_ready : command handshake
//   pc/fetch_pulse/cpu_halted        : CPU status
//   cpu_en/state/bp_en               : sequencer control and status
//   cycle_cnt/instr_cnt              : bring-up counters
// ----------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 32
) ();

    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [PC_W-1:0]  cmd_addr;
    logic             cmd_ready;
    logic [PC_W-1:0]  pc;
    logic             fetch_pulse;
    logic             cpu_halted;
    logic             cpu_en;
    logic [2:0]       state;
    logic             bp_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output cmd_valid, cmd, cmd_addr, pc, fetch_pulse, cpu_halted,
        input  cmd_ready, cpu_en, state, bp_en, cycle_cnt, instr_cnt
    );

    modport slave (
        input  cmd_valid, cmd, cmd_addr, pc, fetch_pulse, cpu_halted,
        output cmd_ready, cpu_en, state, bp_en, cycle_cnt, instr_cnt
    );

endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : count up by one this edge (ignored when saturated)
//   clr        : zero the counter; wins over inc
//   count      : current value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear has priority so a clear issued during an active cycle leaves zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/debug sequencer for the 16-bit multi-cycle CPU. Generates the CPU
// enable from host commands (run, pause, single-step, one PC breakpoint),
// stops for good on the CPU halt flag and keeps cycle / instruction counters.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : cpu_run_ctrl_if.slave (command channel, CPU status, outputs)
// Parameters:
//   PC_W      : PC and breakpoint address width
//   CNT_W     : counter width
//   RESET_RUN : 1 to come out of reset already running
// ----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_RUN = 0
) (
    input logic          clk,
    input logic          reset,
    cpu_run_ctrl_if.slave bus
);

    localparam state_t RST_STATE = (RESET_RUN != 0) ? S_RUN : S_PAUSED;
    localparam logic   RST_EN    = (RESET_RUN != 0);

    state_t          state_q, state_d;
    logic            cpu_en_q;
    logic            skip_bp_q, skip_bp_d;
    logic            bp_en_q, bp_en_d;
    logic [PC_W-1:0] bp_addr_q, bp_addr_d;
    logic            cmd_ready;
    logic            accept;
    logic            bp_hit;
    cmd_t            cmd_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    // Commands are held off only while a single step is in flight.
    assign cmd_ready = (state_q != S_STEP);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign cmd_code  = cmd_t'(bus.cmd);

    // skip_bp lets a resume from BREAK get past the instruction it stopped on.
    assign bp_hit = bus.fetch_pulse && bp_en_q && (bus.pc == bp_addr_q) && !skip_bp_q;

    // Next state, breakpoint register and skip flag. Internal events override
    // commands, and halt overrides everything.
    always_comb begin
        state_d   = state_q;
        skip_bp_d = skip_bp_q;
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;

        if (bus.fetch_pulse) begin
            skip_bp_d = 1'b0;
        end

        if (accept && (cmd_code == CMD_SET_BP)) begin
            bp_en_d   = 1'b1;
            bp_addr_d = bus.cmd_addr;
        end else if (accept && (cmd_code == CMD_CLR_BP)) begin
            bp_en_d = 1'b0;
        end

        case (state_q)
            S_PAUSED: begin
                if (accept && (cmd_code == CMD_RUN)) begin
                    state_d = S_RUN;
                end else if (accept && (cmd_code == CMD_STEP)) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (bp_hit) begin
                    state_d = S_BREAK;
                end else if (accept && (cmd_code == CMD_PAUSE)) begin
                    state_d = S_PAUSED;
                end
            end
            S_STEP: begin
                if (bus.fetch_pulse) begin
                    state_d = S_PAUSED;
                end
            end
            S_BREAK: begin
                if (accept && (cmd_code == CMD_RUN)) begin
                    state_d   = S_RUN;
                    skip_bp_d = 1'b1;
                end else if (accept && (cmd_code == CMD_STEP)) begin
                    state_d = S_STEP;
                end else if (accept && (cmd_code == CMD_PAUSE)) begin
                    state_d = S_PAUSED;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        if (bus.cpu_halted) begin
            state_d = S_DONE;
        end
    end

    // State register; cpu_en is derived from the next state so it changes on
    // the same edge as the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RST_STATE;
            cpu_en_q  <= RST_EN;
            skip_bp_q <= 1'b0;
            bp_en_q   <= 1'b0;
            bp_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= (state_d == S_RUN) || (state_d == S_STEP);
            skip_bp_q <= skip_bp_d;
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_en_q),
        .clr   (accept && (cmd_code == CMD_CLR_CNT)),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_en_q && bus.fetch_pulse),
        .clr   (accept && (cmd_code == CMD_CLR_CNT)),
        .count (instr_cnt)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.cpu_en    = cpu_en_q;
    assign bus.state     = state_q;
    assign bus.bp_en     = bp_en_q;
    assign bus.cycle_cnt = cycle_cnt;
    assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl. A main instance (CNT_W=32,
// RESET_RUN=0) is driven from a vector table whose expected outputs go
// through a scoreboard queue; a second instance (CNT_W=4, RESET_RUN=1)
// covers counter saturation and the run-after-reset variant.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;
    import cpu_pkg::*;

    typedef struct {
        logic        cv;
        logic [2:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  pc;
        logic        fp;
        logic        halt;
        logic [2:0]  st;
        logic        en;
        logic        rdy;
        logic        bp;
        logic [31:0] cyc;
        logic [31:0] ins;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];
    vec_t expQ[$];

    cpu_run_ctrl_if #(.PC_W(8), .CNT_W(32)) m_if ();
    cpu_run_ctrl_if #(.PC_W(8), .CNT_W(4))  s_if ();

    cpu_run_ctrl #(.PC_W(8), .CNT_W(32), .RESET_RUN(0)) dut_main (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if.slave)
    );

    cpu_run_ctrl #(.PC_W(8), .CNT_W(4), .RESET_RUN(1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison with failure report.
    task automatic checkVal(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic addVec(input logic cv, input logic [2:0] cmd, input logic [7:0] addr,
                          input logic [7:0] pc, input logic fp, input logic halt,
                          input logic [2:0] st, input logic en, input logic rdy,
                          input logic bp, input logic [31:0] cyc, input logic [31:0] ins);
        vec_t v;
        v.cv = cv; v.cmd = cmd; v.addr = addr; v.pc = pc; v.fp = fp; v.halt = halt;
        v.st = st; v.en = en; v.rdy = rdy; v.bp = bp; v.cyc = cyc; v.ins = ins;
        vecs.push_back(v);
    endtask

    task automatic driveMain(input logic cv, input logic [2:0] cmd, input logic [7:0] addr,
                             input logic [7:0] pc, input logic fp, input logic halt);
        m_if.cmd_valid   = cv;
        m_if.cmd         = cmd;
        m_if.cmd_addr    = addr;
        m_if.pc          = pc;
        m_if.fetch_pulse = fp;
        m_if.cpu_halted  = halt;
    endtask

    task automatic driveSat(input logic cv, input logic [2:0] cmd);
        s_if.cmd_valid = cv;
        s_if.cmd       = cmd;
    endtask

    // Drive one vector on the falling edge and queue its expected outputs.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveMain(v.cv, v.cmd, v.addr, v.pc, v.fp, v.halt);
        expQ.push_back(v);
    endtask

    // Compare the main instance against the oldest queued expectation.
    task automatic checkOutput(input int idx);
        vec_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard (vector %0d): got empty queue, expected an entry", idx);
        end else begin
            e = expQ.pop_front();
            checkVal("state",     idx, 32'(m_if.state),     32'(e.st));
            checkVal("cpu_en",    idx, 32'(m_if.cpu_en),    32'(e.en));
            checkVal("cmd_ready", idx, 32'(m_if.cmd_ready), 32'(e.rdy));
            checkVal("bp_en",     idx, 32'(m_if.bp_en),     32'(e.bp));
            checkVal("cycle_cnt", idx, m_if.cycle_cnt,      e.cyc);
            checkVal("instr_cnt", idx, m_if.instr_cnt,      e.ins);
        end
    endtask

    task automatic checkMainReset(input int idx);
        checkVal("rst_state",     idx, 32'(m_if.state),     32'(S_PAUSED));
        checkVal("rst_cpu_en",    idx, 32'(m_if.cpu_en),    32'd0);
        checkVal("rst_cmd_ready", idx, 32'(m_if.cmd_ready), 32'd1);
        checkVal("rst_bp_en",     idx, 32'(m_if.bp_en),     32'd0);
        checkVal("rst_cycle_cnt", idx, m_if.cycle_cnt,      32'd0);
        checkVal("rst_instr_cnt", idx, m_if.instr_cnt,      32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        driveMain(1'b0, CMD_NOP, 8'h00, 8'h00, 1'b0, 1'b0);
        driveSat(1'b0, CMD_NOP);
        s_if.cmd_addr    = 8'h00;
        s_if.pc          = 8'h00;
        s_if.fetch_pulse = 1'b0;
        s_if.cpu_halted  = 1'b0;

        // ---------------- vector table for the main instance ----------------
        //     cv cmd          addr   pc     fp halt  st en rdy bp cyc ins
        addVec(1, CMD_RUN,     8'h00, 8'h00, 0, 0,    1, 1, 1, 0, 0,  0);
        for (int k = 1; k <= 10; k++)
            addVec(0, CMD_NOP, 8'h00, 8'h00, 0, 0,    1, 1, 1, 0, k,  0);
        addVec(1, CMD_PAUSE,   8'h00, 8'h00, 0, 0,    0, 0, 1, 0, 11, 0);
        addVec(1, CMD_PAUSE,   8'h00, 8'h00, 0, 0,    0, 0, 1, 0, 11, 0);
        addVec(1, CMD_CLR_CNT, 8'h00, 8'h00, 0, 0,    0, 0, 1, 0, 0,  0);
        addVec(1, CMD_SET_BP,  8'h04, 8'h00, 0, 0,    0, 0, 1, 1, 0,  0);
        addVec(1, CMD_RUN,     8'h00, 8'h00, 0, 0,    1, 1, 1, 1, 0,  0);
        for (int p = 0; p < 4; p++)
            addVec(0, CMD_NOP, 8'h00, 8'(p),  1, 0,   1, 1, 1, 1, p+1, p+1);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 1, 0,    3, 0, 1, 1, 5,  5);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 0, 0,    3, 0, 1, 1, 5,  5);
        addVec(1, CMD_RUN,     8'h00, 8'h04, 0, 0,    1, 1, 1, 1, 5,  5);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 1, 0,    1, 1, 1, 1, 6,  6);
        addVec(0, CMD_NOP,     8'h00, 8'h05, 1, 0,    1, 1, 1, 1, 7,  7);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 1, 0,    3, 0, 1, 1, 8,  8);
        addVec(1, CMD_RUN,     8'h00, 8'h04, 0, 0,    1, 1, 1, 1, 8,  8);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 1, 0,    1, 1, 1, 1, 9,  9);
        addVec(1, CMD_PAUSE,   8'h00, 8'h04, 1, 0,    3, 0, 1, 1, 10, 10);
        addVec(1, CMD_PAUSE,   8'h00, 8'h04, 0, 0,    0, 0, 1, 1, 10, 10);
        addVec(1, CMD_STEP,    8'h00, 8'h00, 0, 0,    2, 1, 0, 1, 10, 10);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 0, 0,    2, 1, 0, 1, 11, 10);
        addVec(1, CMD_RUN,     8'h00, 8'h04, 0, 0,    2, 1, 0, 1, 12, 10);
        addVec(0, CMD_NOP,     8'h00, 8'h04, 1, 0,    0, 0, 1, 1, 13, 11);
        addVec(1, CMD_RUN,     8'h00, 8'h00, 0, 0,    1, 1, 1, 1, 13, 11);
        addVec(1, CMD_PAUSE,   8'h00, 8'h04, 1, 1,    4, 0, 1, 1, 14, 12);
        addVec(1, CMD_RUN,     8'h00, 8'h00, 0, 1,    4, 0, 1, 1, 14, 12);
        addVec(1, CMD_CLR_BP,  8'h00, 8'h00, 0, 1,    4, 0, 1, 0, 14, 12);
        addVec(1, CMD_STEP,    8'h00, 8'h00, 1, 1,    4, 0, 1, 0, 14, 12);

        // ---------------- saturation instance, starts in RUN ----------------
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("sat_rst_state",  0, 32'(s_if.state),  32'(S_RUN));
        checkVal("sat_rst_cpu_en", 0, 32'(s_if.cpu_en), 32'd1);
        checkVal("sat_rst_cycle",  0, 32'(s_if.cycle_cnt), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        checkVal("sat_cycle_14", 0, 32'(s_if.cycle_cnt), 32'd14);
        repeat (6) @(posedge clk);
        #1;
        checkVal("sat_cycle_20", 0, 32'(s_if.cycle_cnt), 32'd15);
        checkVal("sat_instr_20", 0, 32'(s_if.instr_cnt), 32'd0);
        @(negedge clk);
        driveSat(1'b1, CMD_CLR_CNT);
        @(posedge clk);
        #1;
        checkVal("sat_clr_cnt",   0, 32'(s_if.cycle_cnt), 32'd0);
        checkVal("sat_clr_state", 0, 32'(s_if.state),     32'(S_RUN));
        @(negedge clk);
        driveSat(1'b0, CMD_NOP);
        @(posedge clk);
        #1;
        checkVal("sat_after_clr", 0, 32'(s_if.cycle_cnt), 32'd1);

        // ---------------- main instance: reset then table ----------------
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkMainReset(0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(i + 1);
        end

        // ---------------- asynchronous reset in the middle of a step ----------------
        @(negedge clk);
        driveMain(1'b0, CMD_NOP, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        driveMain(1'b1, CMD_SET_BP, 8'h22, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        driveMain(1'b1, CMD_STEP, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        driveMain(1'b0, CMD_NOP, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkVal("step_state",  100, 32'(m_if.state),     32'(S_STEP));
        checkVal("step_bp_en",  100, 32'(m_if.bp_en),     32'd1);
        checkVal("step_cycle",  100, m_if.cycle_cnt,      32'd1);
        checkVal("step_ready",  100, 32'(m_if.cmd_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkMainReset(101);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
